seg7_scan_mux: RTL
==================

// Module: seg7_scan_mux
// PURPOSE
//  Parametrised, time-multiplexed seven-segment driver for the keycode display path. Replaces the fixed 4-digit scan
//  inside main: N hex digits, per-digit DP/blank masks, leading-zero suppression, anti-ghost dead time, and
//  tear-free double-buffered updates committed only at frame boundaries. Input from the PS/2 keycode register; output to board pins.
// PARAMETERS
//  NUM_DIGITS   4       digits scanned (1..8); data_in holds 4*NUM_DIGITS bits
//  REFRESH_DIV  100000  clk cycles per digit slot (>=4)
//  DEAD_CYCLES  16      cycles at start of each slot with all anodes off (< REFRESH_DIV-1)
//  ACTIVE_LOW   1       1: SEG/AN/DP low-active (board default); 0: high-active
// PORTS
//  clk          in   1             system clock
//  reset        in   1             synchronous, active-high
//  data_in      in   4*NUM_DIGITS  hex nibbles; nibble 0 = rightmost digit (AN[0])
//  data_valid   in   1             one-cycle load strobe for data_in/dp_in/blank_in
//  dp_in        in   NUM_DIGITS    per-digit decimal point request
//  blank_in     in   NUM_DIGITS    per-digit forced blank (kills SEG, DP, AN)
//  lz_suppress  in   1             1: blank leading zero digits (digit 0 never suppressed)
//  SEG          out  7             segments {g,f,e,d,c,b,a}, registered
//  AN           out  NUM_DIGITS    digit anodes, one-hot active, registered
//  DP           out  1             decimal point, registered
//  frame_tick   out  1             1-cycle pulse when scan wraps to digit 0
// BEHAVIOUR
//  - Clock and reset: one clock, clk. reset is synchronous and active-high.
//  - Reset: prescaler=0, digit_idx=0, dead counter=DEAD_CYCLES, shadow/pending regs=0, pend_flag=0; frame_tick=0;
//    SEG/AN/DP all inactive (ACTIVE_LOW=1: SEG=7'h7F, AN=all 1s, DP=1). Reset mid-frame aborts scan; pending data is lost.
//  - Prescaler counts 0..REFRESH_DIV-1 and wraps; slot_tick when count==REFRESH_DIV-1.
//  - On slot_tick: digit_idx increments, wrapping NUM_DIGITS-1 -> 0; dead counter reloads DEAD_CYCLES.
//    On the NUM_DIGITS-1 -> 0 wrap, frame_tick=1 in the same cycle as the index update.
//  - While the dead counter is nonzero, AN is all inactive, SEG is inactive, and the counter decrements.
//    Otherwise outputs show shadow digit digit_idx. Each slot has AN active for exactly REFRESH_DIV-DEAD_CYCLES cycles.
//  - Outputs are registered: 1-cycle latency from the index/dead counter to the pins.
//  - data_valid captures data_in, dp_in and blank_in into the pending regs and sets pend_flag. If several strobes
//    arrive within one frame, the last one wins.
//  - At a frame boundary (frame_tick cycle): if pend_flag, shadow <= pending and pend_flag is cleared.
//    data_valid in the same cycle as the boundary goes straight to shadow (new data wins) and pend_flag stays 0.
//    The shadow never changes mid-frame.
//  - Leading zeros: digit i>0 is suppressed when lz_suppress=1 and shadow nibbles i..NUM_DIGITS-1 are all 0.
//    A suppressed digit has AN inactive and SEG inactive, but DP still follows dp_in (AN asserted only if DP set).
//    lz_suppress is sampled live, not buffered.
//  - blank_in digit: AN, SEG and DP inactive, overriding everything.
//  - Hex decode (active-high, {g..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//    When ACTIVE_LOW=1, all outputs are inverted.
//  - Widths: prescaler $clog2(REFRESH_DIV), digit_idx $clog2(NUM_DIGITS) (min 1), dead counter $clog2(DEAD_CYCLES+1).
// STRUCTURE
//  - Shared package seg7_pkg: SEG_* hex-decode constants and SEG_BLANK.
//  - One sub-module, hex_to_seg7: combinational nibble -> 7-bit active-high pattern.
//  - Top holds the prescaler, scan/dead counters, pending/shadow buffers, LZ mask logic, polarity and output regs.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, ACTIVE_LOW=1; SEG values active-low)
//  1. reset=1 for 5 clk -> SEG=7'h7F, AN=4'b1111, DP=1, frame_tick=0 on every cycle.
//  2. data_in=16'h161E, data_valid pulse -> from the frame after the next frame_tick, AN cycles 1110/1101/1011/0111
//     with SEG=06,79,02,79 (E,1,6,1).
//  3. Tear-free: during a frame showing 161E, load 16'hAA16 at digit 1 -> digits 2,3 still show 6,1 until frame_tick;
//     the next frame shows 6,1,A,A.
//  4. lz_suppress=1, data 16'h0016 -> AN goes low only at 1110 and 1101; slots 2,3 stay 1111 with SEG=7F.
//     Same with dp_in=4'b1000 -> slot 3 has AN=0111, SEG=7F, DP=0.
//  5. Dead time: each 8-cycle slot has AN=1111 for 2 cycles, then one-hot for 6; frame_tick has period 32.
//     data_valid on the frame_tick cycle shows the new data at once.
//  6. reset pulse mid-slot 2 with pend_flag set -> all outputs inactive next cycle; scan restarts at digit 0
//     with shadow=0 ("0000"); pending data discarded.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-high {g,f,e,d,c,b,a} glyphs for hex digits.
package seg7_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Load/display bundle between the keycode register, the scan driver and the board pins.
interface seg7_scan_mux_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] data_in;
  logic                    data_valid;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    lz_suppress;
  logic [6:0]              SEG;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    DP;
  logic                    frame_tick;

  // Source of display data; observes pins and frame boundary.
  modport master (
    output data_in, data_valid, dp_in, blank_in, lz_suppress,
    input  SEG, AN, DP, frame_tick
  );

  // Scan driver.
  modport slave (
    input  data_in, data_valid, dp_in, blank_in, lz_suppress,
    output SEG, AN, DP, frame_tick
  );
endinterface

// File: rtl/seg7_scan_mux_hex_to_seg7.sv
// Combinational nibble to active-high seven-segment glyph.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (nibble)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit hex display driver with dead time, leading-zero
// suppression and frame-aligned double buffering of the displayed value.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 16,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input logic            clk,
  input logic            reset,
  seg7_scan_mux_if.slave bus
);

  localparam int unsigned DATA_W = NIBBLE_W * NUM_DIGITS;
  localparam int unsigned PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DEAD_W = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

  // XOR masks that map active-high internal values onto pin polarity.
  localparam logic [SEG_W-1:0]      SEG_POL = {SEG_W{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic                  DP_POL  = ACTIVE_LOW;

  logic [PRE_W-1:0]      pre_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic [DEAD_W-1:0]     dead_cnt;
  logic                  frame_tick_q;

  logic [DATA_W-1:0]     pend_data;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic                  pend_flag;

  logic [DATA_W-1:0]     shad_data;
  logic [NUM_DIGITS-1:0] shad_dp;
  logic [NUM_DIGITS-1:0] shad_blank;

  logic [DATA_W-1:0]     shad_data_c;
  logic [NUM_DIGITS-1:0] shad_dp_c;
  logic [NUM_DIGITS-1:0] shad_blank_c;

  logic [SEG_W-1:0]      seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  dp_q;

  logic                  slot_tick_c;
  logic                  wrap_c;
  logic [NUM_DIGITS-1:0] zero_above_c;
  logic                  zero_run_c;
  logic [NIBBLE_W-1:0]   cur_nib_c;
  logic                  cur_dp_c;
  logic                  cur_blank_c;
  logic                  cur_lz_c;
  logic [NUM_DIGITS-1:0] an_sel_c;
  logic [SEG_W-1:0]      seg_dec_c;
  logic [SEG_W-1:0]      seg_on_c;
  logic [NUM_DIGITS-1:0] an_on_c;
  logic                  dp_on_c;

  assign slot_tick_c = (pre_cnt == PRE_W'(REFRESH_DIV - 1));
  assign wrap_c      = slot_tick_c && (digit_idx == IDX_W'(NUM_DIGITS - 1));

  // Shadow only moves in the frame_tick cycle; a strobe in that cycle beats the pending copy.
  always_comb begin
    shad_data_c  = shad_data;
    shad_dp_c    = shad_dp;
    shad_blank_c = shad_blank;
    if (frame_tick_q) begin
      if (bus.data_valid) begin
        shad_data_c  = bus.data_in;
        shad_dp_c    = bus.dp_in;
        shad_blank_c = bus.blank_in;
      end else if (pend_flag) begin
        shad_data_c  = pend_data;
        shad_dp_c    = pend_dp;
        shad_blank_c = pend_blank;
      end
    end
  end

  // zero_above_c[i]: nibbles i..NUM_DIGITS-1 of the shadow are all zero.
  always_comb begin
    zero_above_c = '0;
    zero_run_c   = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run_c      = zero_run_c && (shad_data_c[i*NIBBLE_W +: NIBBLE_W] == '0);
      zero_above_c[i] = zero_run_c;
    end
  end

  always_comb begin
    cur_nib_c   = '0;
    cur_dp_c    = 1'b0;
    cur_blank_c = 1'b0;
    cur_lz_c    = 1'b0;
    an_sel_c    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        cur_nib_c   = shad_data_c[i*NIBBLE_W +: NIBBLE_W];
        cur_dp_c    = shad_dp_c[i];
        cur_blank_c = shad_blank_c[i];
        cur_lz_c    = bus.lz_suppress && (i != 0) && zero_above_c[i];
        an_sel_c[i] = 1'b1;
      end
    end
  end

  hex_to_seg7 u_dec (
    .nibble (cur_nib_c),
    .seg_c  (seg_dec_c)
  );

  // Suppressed leading zeros keep their decimal point, lighting the anode only for it.
  always_comb begin
    seg_on_c = SEG_BLANK;
    an_on_c  = '0;
    dp_on_c  = 1'b0;
    if ((dead_cnt == '0) && !cur_blank_c) begin
      dp_on_c = cur_dp_c;
      if (cur_lz_c) begin
        an_on_c = cur_dp_c ? an_sel_c : '0;
      end else begin
        seg_on_c = seg_dec_c;
        an_on_c  = an_sel_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt      <= '0;
      digit_idx    <= '0;
      dead_cnt     <= DEAD_W'(DEAD_CYCLES);
      frame_tick_q <= 1'b0;
      pend_data    <= '0;
      pend_dp      <= '0;
      pend_blank   <= '0;
      pend_flag    <= 1'b0;
      shad_data    <= '0;
      shad_dp      <= '0;
      shad_blank   <= '0;
      seg_q        <= SEG_POL;
      an_q         <= AN_POL;
      dp_q         <= DP_POL;
    end else begin
      pre_cnt <= slot_tick_c ? '0 : pre_cnt + PRE_W'(1);

      if (slot_tick_c) begin
        digit_idx <= wrap_c ? '0 : digit_idx + IDX_W'(1);
        dead_cnt  <= DEAD_W'(DEAD_CYCLES);
      end else if (dead_cnt != '0) begin
        dead_cnt <= dead_cnt - DEAD_W'(1);
      end

      frame_tick_q <= wrap_c;

      shad_data  <= shad_data_c;
      shad_dp    <= shad_dp_c;
      shad_blank <= shad_blank_c;

      if (frame_tick_q) begin
        pend_flag <= 1'b0;
      end else if (bus.data_valid) begin
        pend_data  <= bus.data_in;
        pend_dp    <= bus.dp_in;
        pend_blank <= bus.blank_in;
        pend_flag  <= 1'b1;
      end

      seg_q <= seg_on_c ^ SEG_POL;
      an_q  <= an_on_c ^ AN_POL;
      dp_q  <= dp_on_c ^ DP_POL;
    end
  end

  assign bus.SEG        = seg_q;
  assign bus.AN         = an_q;
  assign bus.DP         = dp_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
